// File: rtl/ysyx_23060136_pipe_ctrl.sv
// Pipeline sequencing controller: stall/flush arbitration for PC and segment
// registers, halt FSM with MEM bus-timeout watchdog, and performance counters.
module ysyx_23060136_pipe_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IFU_o_valid,
  input  logic             ID_load_use,
  input  logic             EXU_o_branch_taken,
  input  logic             MEM_o_req,
  input  logic             MEM_i_done,
  input  logic             WB_i_commit,
  input  logic             WB_i_system_halt,
  output logic             FORWARD_stallIF,
  output logic             FORWARD_stallID,
  output logic             FORWARD_stallEX,
  output logic             FORWARD_stallME,
  output logic             FORWARD_stallWB,
  output logic             FORWARD_flushIF,
  output logic             FORWARD_flushID,
  output logic             FORWARD_flushEX,
  output logic             FORWARD_flushME,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_HALT
  } state_e;

  state_e            state_q;
  logic [WAIT_W-1:0] wait_q;
  logic              bus_err_q;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  inst_q, inst_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic              in_halt;
  logic              bus_wait;
  logic              halt_commit;
  logic              count_en;
  logic [4:0]        stall_vec;   // {IF, ID, EX, ME, WB}
  logic [3:0]        flush_vec;   // {IF, ID, EX, ME}

  assign in_halt     = (state_q == S_HALT);
  assign halt_commit = WB_i_commit && WB_i_system_halt;

  // A request answered in its own cycle never stalls; only an outstanding one does.
  assign bus_wait = ((state_q == S_MEM_WAIT) && !MEM_i_done) ||
                    ((state_q == S_RUN) && MEM_o_req && !MEM_i_done);

  // NOTE: every output gets a default before the priority chain so no latch is inferred.
  always_comb begin
    stall_vec = 5'b00000;
    flush_vec = 4'b0000;
    if (in_halt) begin
      stall_vec = 5'b11111;
    end else if (rst) begin
      stall_vec = 5'b00000;
    end else if (bus_wait) begin
      stall_vec = 5'b11111;
    end else if (EXU_o_branch_taken) begin
      flush_vec = 4'b1100;
    end else if (ID_load_use) begin
      stall_vec = 5'b11000;
      flush_vec = 4'b0100;
    end else if (!IFU_o_valid) begin
      stall_vec = 5'b10000;
      flush_vec = 4'b1000;
    end
  end

  assign {FORWARD_stallIF, FORWARD_stallID, FORWARD_stallEX,
          FORWARD_stallME, FORWARD_stallWB} = stall_vec;
  assign {FORWARD_flushIF, FORWARD_flushID,
          FORWARD_flushEX, FORWARD_flushME} = flush_vec;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (halt_commit) begin
            state_q <= S_HALT;
          end else if (MEM_o_req && !MEM_i_done) begin
            state_q <= S_MEM_WAIT;
            wait_q  <= '0;
          end
        end
        S_MEM_WAIT: begin
          if (MEM_i_done) begin
            state_q <= S_RUN;
          end else if (wait_q == WAIT_LAST) begin
            state_q   <= S_HALT;
            bus_err_q <= 1'b1;
          end else if (wait_q != WAIT_MAX) begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_RUN;
      endcase
    end
  end

  // Counters freeze in HALT and during reset; retires are counted even under a bus wait.
  assign count_en = !rst && !in_halt;
  assign cyc_d    = count_en ? cyc_q + CNT_W'(1) : cyc_q;
  assign inst_d   = (count_en && WB_i_commit) ? inst_q + CNT_W'(1) : inst_q;
  assign stall_d  = (count_en && stall_vec[4]) ? stall_q + CNT_W'(1) : stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= '0;
      inst_q  <= '0;
      stall_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      inst_q  <= inst_d;
      stall_q <= stall_d;
    end
  end

  assign halted    = in_halt;
  assign bus_err   = bus_err_q;
  assign cyc_cnt   = cyc_q;
  assign inst_cnt  = inst_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_ysyx_23060136_pipe_ctrl.sv
// Directed self-checking bench for ysyx_23060136_pipe_ctrl (MEM_TIMEOUT=8).
module tb_ysyx_23060136_pipe_ctrl;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 8;

  // Control vector order: {stallIF, ID, EX, ME, WB, flushIF, ID, EX, ME}
  localparam logic [8:0] C_NONE  = 9'b00000_0000;
  localparam logic [8:0] C_STALL = 9'b11111_0000;
  localparam logic [8:0] C_REDIR = 9'b00000_1100;
  localparam logic [8:0] C_LU    = 9'b11000_0100;
  localparam logic [8:0] C_BUB   = 9'b10000_1000;

  logic clk = 1'b0;
  logic rst;
  logic ifu_valid, load_use, br_taken, mem_req, mem_done, commit, sys_halt;
  logic s_if, s_id, s_ex, s_me, s_wb, f_if, f_id, f_ex, f_me;
  logic halted, bus_err;
  logic [CNT_W-1:0] cyc_cnt, inst_cnt, stall_cnt;
  logic [8:0] ctrl;
  logic [6:0] rnd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060136_pipe_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .rst               (rst),
    .IFU_o_valid       (ifu_valid),
    .ID_load_use       (load_use),
    .EXU_o_branch_taken(br_taken),
    .MEM_o_req         (mem_req),
    .MEM_i_done        (mem_done),
    .WB_i_commit       (commit),
    .WB_i_system_halt  (sys_halt),
    .FORWARD_stallIF   (s_if),
    .FORWARD_stallID   (s_id),
    .FORWARD_stallEX   (s_ex),
    .FORWARD_stallME   (s_me),
    .FORWARD_stallWB   (s_wb),
    .FORWARD_flushIF   (f_if),
    .FORWARD_flushID   (f_id),
    .FORWARD_flushEX   (f_ex),
    .FORWARD_flushME   (f_me),
    .halted            (halted),
    .bus_err           (bus_err),
    .cyc_cnt           (cyc_cnt),
    .inst_cnt          (inst_cnt),
    .stall_cnt         (stall_cnt)
  );

  assign ctrl = {s_if, s_id, s_ex, s_me, s_wb, f_if, f_id, f_ex, f_me};

  task automatic check_ctrl(input string tag, input logic [8:0] exp);
    checks++;
    assert (ctrl === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, ctrl, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] obs,
                           input logic [CNT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_counters(input string tag, input int c, input int i, input int s);
    check_cnt({tag, ".cyc"},   cyc_cnt,   CNT_W'(c));
    check_cnt({tag, ".inst"},  inst_cnt,  CNT_W'(i));
    check_cnt({tag, ".stall"}, stall_cnt, CNT_W'(s));
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_valid = 1'b1;
    load_use  = 1'b0;
    br_taken  = 1'b0;
    mem_req   = 1'b0;
    mem_done  = 1'b0;
    commit    = 1'b0;
    sys_halt  = 1'b0;
  endtask

  task automatic random_inputs();
    rnd = 7'($urandom);
    {ifu_valid, load_use, br_taken, mem_req, mem_done, commit, sys_halt} = rnd;
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    random_inputs();
    cyc();
    random_inputs();
    #1;
    check_ctrl("rst_cyc1_ctrl", C_NONE);
    cyc();
    random_inputs();
    #1;
    check_ctrl("rst_cyc2_ctrl", C_NONE);
    check_bit("rst_halted", halted, 1'b0);
    check_bit("rst_bus_err", bus_err, 1'b0);
    check_counters("rst", 0, 0, 0);

    rst = 1'b0;
    idle_inputs();
    #1;
    check_ctrl("idle_ctrl", C_NONE);
    cyc();
    check_counters("idle1", 1, 0, 0);

    // 4-cycle bus response: 3 stalled cycles
    mem_req = 1'b1;
    #1;
    check_ctrl("bw_c1", C_STALL);
    cyc();
    check_ctrl("bw_c2", C_STALL);
    cyc();
    check_ctrl("bw_c3", C_STALL);
    cyc();
    mem_done = 1'b1;
    #1;
    check_ctrl("bw_c4_done", C_NONE);
    cyc();
    idle_inputs();
    #1;
    check_ctrl("bw_back_run", C_NONE);
    check_counters("bw", 5, 0, 3);

    // 1-cycle response: no stall
    mem_req  = 1'b1;
    mem_done = 1'b1;
    #1;
    check_ctrl("bw_1cyc", C_NONE);
    cyc();
    idle_inputs();
    #1;
    check_counters("bw1", 6, 0, 3);

    // Hazard priority (combinational only, no clock edge)
    br_taken  = 1'b1;
    load_use  = 1'b1;
    ifu_valid = 1'b0;
    #1;
    check_ctrl("redir_over_all", C_REDIR);
    br_taken = 1'b0;
    #1;
    check_ctrl("lu_over_bubble", C_LU);
    load_use = 1'b0;
    #1;
    check_ctrl("fetch_bubble", C_BUB);
    idle_inputs();
    #1;

    // Redirect during a bus wait: held until the done cycle
    mem_req  = 1'b1;
    br_taken = 1'b1;
    #1;
    check_ctrl("rbw_c1", C_STALL);
    cyc();
    check_ctrl("rbw_c2", C_STALL);
    cyc();
    mem_done = 1'b1;
    #1;
    check_ctrl("rbw_done", C_REDIR);
    cyc();
    idle_inputs();
    #1;
    check_counters("rbw", 9, 0, 5);

    // Halt: 5 commits, the last with halt and a concurrent bus request
    commit = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    sys_halt = 1'b1;
    mem_req  = 1'b1;
    #1;
    check_ctrl("halt_commit_cyc", C_STALL);
    check_bit("halt_not_yet", halted, 1'b0);
    cyc();
    sys_halt = 1'b0;
    mem_req  = 1'b0;
    #1;
    check_bit("halted", halted, 1'b1);
    check_ctrl("halt_ctrl", C_STALL);
    check_counters("halt", 14, 5, 6);
    cyc();
    cyc();
    check_counters("halt_frozen", 14, 5, 6);
    check_bit("halt_no_bus_err", bus_err, 1'b0);
    idle_inputs();
    rst = 1'b1;
    #1;
    check_ctrl("halt_over_rst", C_STALL);
    cyc();
    check_bit("rst_from_halt", halted, 1'b0);
    check_ctrl("rst_from_halt_ctrl", C_NONE);
    check_counters("rst_from_halt", 0, 0, 0);
    rst = 1'b0;

    // Timeout: MEM_i_done never arrives
    mem_req = 1'b1;
    #1;
    cyc();
    for (int k = 0; k < TIMEOUT - 1; k++) cyc();
    check_bit("to_before_halted", halted, 1'b0);
    check_bit("to_before_bus_err", bus_err, 1'b0);
    check_ctrl("to_before_ctrl", C_STALL);
    cyc();
    check_bit("to_halted", halted, 1'b1);
    check_bit("to_bus_err", bus_err, 1'b1);
    check_counters("to", 9, 0, 9);
    cyc();
    cyc();
    check_cnt("to_cyc_frozen", cyc_cnt, CNT_W'(9));
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check_bit("to_rst_halted", halted, 1'b0);
    check_bit("to_rst_bus_err", bus_err, 1'b0);
    check_ctrl("to_rst_ctrl", C_NONE);
    cyc();
    check_cnt("to_rst_cyc", cyc_cnt, CNT_W'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060136_pipe_ctrl.md
# ysyx_23060136_pipe_ctrl

Pipeline sequencing controller for the five-stage core. It drives the stall (hold) and flush (bubble) controls of the PC and the four segment registers IF_ID, ID_EX, EX_MEM and MEM_WB. It arbitrates between bus-wait, branch-redirect, load-use and fetch-bubble hazards. It also owns the halt state machine, a MEM bus-timeout watchdog and the performance counters.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.
- MEM_TIMEOUT, 1023, maximum number of MEM_WAIT cycles before a bus error is declared (must be ≥ 1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- IFU_o_valid  in  1  fetch delivers a valid instruction this cycle.
- ID_load_use  in  1  ID instruction reads the rd of a load currently in EX.
- EXU_o_branch_taken  in  1  EX resolves a taken branch or jump (redirect).
- MEM_o_req  in  1  MEM-stage instruction needs the data bus.
- MEM_i_done  in  1  data-bus response for the MEM request.
- WB_i_commit  in  1  WB instruction retires this cycle.
- WB_i_system_halt  in  1  retiring instruction is ebreak/halt.
- FORWARD_stallIF  out  1  hold PC.
- FORWARD_stallID / stallEX / stallME / stallWB  out  1 each  hold IF_ID / ID_EX / EX_MEM / MEM_WB.
- FORWARD_flushIF / flushID / flushEX / flushME  out  1 each  load a bubble into IF_ID / ID_EX / EX_MEM / MEM_WB (effective only when the matching stall is 0).
- halted  out  1  core halted by ebreak or bus error.
- bus_err  out  1  sticky flag set by the MEM timeout.
- cyc_cnt, inst_cnt, stall_cnt  out  CNT_W each  cycles, retired instructions, and stalled cycles.

## Operation
The FSM has three states: RUN, MEM_WAIT and HALT. Stall and flush outputs are combinational from the state and the inputs. Counters and the FSM are registered.

State transitions:
- RUN to MEM_WAIT: MEM_o_req and not MEM_i_done.
- RUN to HALT: WB_i_commit and WB_i_system_halt.
- MEM_WAIT to RUN: MEM_i_done.
- MEM_WAIT to HALT: wait counter reaches MEM_TIMEOUT without MEM_i_done. bus_err is set on this transition.
- HALT is left only via rst.

Output priority, highest first:
1. HALT: all five stalls 1, all flushes 0, halted=1.
2. rst high: all stalls and flushes 0.
3. Bus wait (state MEM_WAIT and not MEM_i_done, or RUN with MEM_o_req and not MEM_i_done): stallIF/ID/EX/ME/WB=1, all flushes 0. stallWB makes MEM_WB re-present held data with commit cleared, so no double retire occurs.
4. Redirect (EXU_o_branch_taken): flushIF=1, flushID=1, all stalls 0. This overrides load-use and fetch bubble, because the IF and ID instructions are wrong-path.
5. Load-use (ID_load_use): stallIF=1, stallID=1, flushID=1, others 0.
6. Fetch bubble (not IFU_o_valid): stallIF=1, flushIF=1, others 0.
7. Otherwise all stalls and flushes are 0.

Other rules:
- A retire coinciding with a bus wait still counts. Retire is judged only on WB_i_commit.
- The wait counter clears on entry to MEM_WAIT and counts each MEM_WAIT cycle. It saturates at MEM_TIMEOUT.
- cyc_cnt increments every cycle that is not rst and not HALT.
- inst_cnt increments on WB_i_commit while not in HALT. The halting instruction itself is counted.
- stall_cnt increments on every non-HALT, non-rst cycle with FORWARD_stallIF=1.
- All counters wrap modulo 2^CNT_W.

## Timing
Reset values, in the cycle after rst: state RUN, wait counter 0, halted 0, bus_err 0, all counters 0.

Latency:
- The hazard-to-control path is zero-cycle, so the controls act at the same posedge.
- A 1-cycle bus response (MEM_o_req and MEM_i_done together) produces no stall.
- An N-cycle response produces exactly N-1 stalled cycles.
- halted rises the cycle after the halting commit.
- bus_err and halted rise the cycle after the MEM_TIMEOUT-th wait cycle.

Boundary conditions:
- Redirect during a bus wait: the bus wait wins. EX is held, so EXU_o_branch_taken stays asserted and the redirect takes effect in the MEM_i_done cycle.
- Halt commit and MEM_o_req in the same cycle: go to HALT; the bus request is abandoned.
- rst mid-MEM_WAIT or in HALT: return to RUN next cycle and clear every output.

## Test plan
- Reset: hold rst 2 cycles with random inputs -> all outputs 0; after rst, cyc_cnt=1 after one idle cycle.
- Bus wait: MEM_o_req=1, MEM_i_done on the 4th cycle -> exactly 3 cycles with all stalls=1 and no flushes; stall_cnt=3; return to RUN.
- Redirect plus load-use plus invalid fetch in the same cycle -> flushIF=flushID=1, all stalls 0.
- Redirect during MEM_WAIT -> stalls only, no flush, until the MEM_i_done cycle; flushIF=flushID=1 in that cycle.
- Timeout: MEM_TIMEOUT=8 and MEM_i_done never arrives -> bus_err=1 and halted=1 after 8 wait cycles; cyc_cnt frozen; rst clears both flags.
- Halt: 5 commits, the 5th with WB_i_system_halt -> inst_cnt=5, halted=1 next cycle, all stalls 1, and later commits are not counted.
